// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state encoding and NOP word for the fetch stage
package fetch_pkg;
  localparam int PC_W = 12;
  localparam int INST_W = 16;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;
endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: no-ack cycle counter with sticky error flag once TIMEOUT_CYC is reached
module fetch_timeout #(
  parameter int TIMEOUT_CYC = 15
) (
  input logic clk,
  input logic reset,
  input logic clr,
  input logic inc,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == CW'(TIMEOUT_CYC)) ? cnt : cnt + 1'b1;
      err <= err | (cnt == CW'(TIMEOUT_CYC - 1));
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IDLE/REQ/HOLD instruction fetch with one-entry skid and IF/ID register; FETCH_STAGE_TIMEOUT_EN adds the imem timeout flag
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 12'h000,
  parameter int TIMEOUT_CYC = 15
) (
  input logic clk,
  input logic reset,
  input logic stallD,
  input logic branchD,
  input logic [PC_W-1:0] PC_branch,
  output logic imem_req,
  output logic [PC_W-1:0] imem_addr,
  input logic imem_ack,
  input logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] instD,
  output logic [PC_W-1:0] pcD,
  output logic validD,
  output logic fetch_err
);
  state_t state;
  logic [PC_W-1:0] pc_f;
  logic [INST_W-1:0] skid;
  always_comb begin
    imem_req = (state == REQ);
    imem_addr = pc_f;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_f <= RESET_PC;
      instD <= NOP_INST;
      pcD <= '0;
      validD <= 1'b0;
      skid <= NOP_INST;
    end else if (branchD) begin
      state <= REQ;
      pc_f <= PC_branch;
      validD <= 1'b0;
    end else if (state == IDLE) begin
      state <= REQ;
    end else if (state == REQ) begin
      if (imem_ack && stallD) begin
        skid <= imem_rdata;
        state <= HOLD;
      end else if (imem_ack) begin
        instD <= imem_rdata;
        pcD <= pc_f;
        validD <= 1'b1;
        pc_f <= pc_f + 1'b1;
      end else if (!stallD) begin
        validD <= 1'b0;
      end
    end else if (!stallD) begin
      instD <= skid;
      pcD <= pc_f;
      validD <= 1'b1;
      pc_f <= pc_f + 1'b1;
      state <= REQ;
    end
  end
`ifdef FETCH_STAGE_TIMEOUT_EN
  fetch_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clr(imem_ack | branchD),
    .inc((state == REQ) & ~imem_ack & ~branchD),
    .err(fetch_err)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
`ifdef FETCH_STAGE_TIMEOUT_EN
  localparam logic TO = 1'b1;
`else
  localparam logic TO = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, stallD, branchD, imem_ack;
  logic [11:0] PC_branch;
  logic [15:0] imem_rdata;
  logic imem_req, validD, fetch_err;
  logic [11:0] imem_addr, pcD;
  logic [15:0] instD;
  logic [27:0] sb[$];
  logic [27:0] e;
  int checks = 0;
  int errors = 0;
  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stallD(stallD),
    .branchD(branchD),
    .PC_branch(PC_branch),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instD(instD),
    .pcD(pcD),
    .validD(validD),
    .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && validD && !stallD) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ifid: got pc %h inst %h expected none", pcD, instD);
      end else begin
        e = sb.pop_front();
        chk("pcD", {20'd0, pcD}, {20'd0, e[27:16]});
        chk("instD", {16'd0, instD}, {16'd0, e[15:0]});
      end
    end
  end
  task automatic step(input logic s, input logic b, input logic [11:0] t, input logic a,
                      input logic [15:0] d, input logic rq, input logic [11:0] ad, input logic v);
    stallD = s;
    branchD = b;
    PC_branch = t;
    imem_ack = a;
    imem_rdata = d;
    if (rq && a && !b) sb.push_back({ad, d});
    @(negedge clk);
    chk("imem_req", {31'd0, imem_req}, {31'd0, rq});
    chk("imem_addr", {20'd0, imem_addr}, {20'd0, ad});
    chk("validD", {31'd0, validD}, {31'd0, v});
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    stallD = 1'b0;
    branchD = 1'b0;
    PC_branch = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, validD}, 32'd0);
    chk("rst_instD", {16'd0, instD}, 32'd0);
    chk("rst_pcD", {20'd0, pcD}, 32'd0);
    chk("rst_addr", {20'd0, imem_addr}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 12'h000, 0, 16'h0000, 0, 12'h000, 0);
    step(0, 0, 12'h000, 1, 16'hA000, 1, 12'h000, 0);
    step(0, 0, 12'h000, 1, 16'hA001, 1, 12'h001, 1);
    step(0, 0, 12'h000, 1, 16'hA002, 1, 12'h002, 1);
    step(0, 0, 12'h000, 1, 16'hA003, 1, 12'h003, 1);
    step(0, 0, 12'h000, 1, 16'hA004, 1, 12'h004, 1);
    step(1, 0, 12'h000, 1, 16'h1234, 1, 12'h005, 1);
    step(1, 0, 12'h000, 0, 16'h0000, 0, 12'h005, 1);
    step(0, 0, 12'h000, 0, 16'h0000, 0, 12'h005, 1);
    step(0, 0, 12'h000, 1, 16'hB006, 1, 12'h006, 1);
    step(0, 0, 12'h000, 0, 16'h0000, 1, 12'h007, 1);
    step(0, 0, 12'h000, 1, 16'hB007, 1, 12'h007, 0);
    step(1, 0, 12'h000, 0, 16'h0000, 1, 12'h008, 1);
    step(0, 0, 12'h000, 0, 16'h0000, 1, 12'h008, 1);
    step(0, 1, 12'h0A0, 1, 16'hDEAD, 1, 12'h008, 0);
    step(0, 0, 12'h000, 1, 16'hC0A0, 1, 12'h0A0, 0);
    step(0, 1, 12'hFFE, 0, 16'h0000, 1, 12'h0A1, 1);
    step(0, 0, 12'h000, 1, 16'hDFFE, 1, 12'hFFE, 0);
    step(0, 0, 12'h000, 1, 16'hDFFF, 1, 12'hFFF, 1);
    step(0, 0, 12'h000, 1, 16'hD000, 1, 12'h000, 1);
    step(0, 0, 12'h000, 0, 16'h0000, 1, 12'h001, 1);
    chk("err_early", {31'd0, fetch_err}, 32'd0);
    for (int i = 0; i < 15; i++) step(0, 0, 12'h000, 0, 16'h0000, 1, 12'h001, 0);
    chk("err_timeout", {31'd0, fetch_err}, {31'd0, TO});
    step(0, 0, 12'h000, 1, 16'hE001, 1, 12'h001, 0);
    step(0, 0, 12'h000, 1, 16'hE002, 1, 12'h002, 1);
    chk("err_sticky", {31'd0, fetch_err}, {31'd0, TO});
    step(1, 0, 12'h000, 1, 16'hF003, 1, 12'h003, 1);
    step(1, 0, 12'h000, 0, 16'h0000, 0, 12'h003, 1);
    reset = 1'b1;
    stallD = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 16'h5555;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    stallD = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("hrst_valid", {31'd0, validD}, 32'd0);
    chk("hrst_req", {31'd0, imem_req}, 32'd0);
    chk("hrst_addr", {20'd0, imem_addr}, 32'd0);
    chk("hrst_instD", {16'd0, instD}, 32'd0);
    chk("hrst_pcD", {20'd0, pcD}, 32'd0);
    chk("hrst_err", {31'd0, fetch_err}, 32'd0);
    @(posedge clk);
    #1;
    step(0, 0, 12'h000, 1, 16'h7777, 1, 12'h000, 0);
    step(0, 0, 12'h000, 0, 16'h0000, 1, 12'h001, 1);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
